// File: rtl/sop_pkg.sv
// Shared constants for the sum-of-products datapath and its BCD display converter.
package sop_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT
  } state_t;

  localparam int SOP_W      = 9;
  localparam int SOP_DIGITS = 3;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // True when every IN_W-bit value fits in the given number of decimal digits.
  function automatic bit bcd_params_ok(input int in_w, input int digits);
    longint unsigned p2;
    longint unsigned p10;
    if (in_w < 1 || in_w > 62 || digits < 1 || digits > 18) return 1'b0;
    p2  = 1;
    p10 = 1;
    for (int i = 0; i < in_w; i++)   p2  = p2 * 2;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    return p2 <= p10;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 correction: digits of 5 or more get +3
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj
  import sop_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/sop_bcd_conv.sv
// Iterative binary-to-BCD converter (one bit per clock) for the sum-of-products
// result; bcd only changes when a conversion completes, keeping the display steady.
module sop_bcd_conv
  import sop_pkg::*;
#(
  parameter int IN_W   = SOP_W,
  parameter int DIGITS = SOP_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (!bcd_params_ok(IN_W, DIGITS)) begin : g_bad_params
    $error("sop_bcd_conv: 2**IN_W must not exceed 10**DIGITS");
  end

  state_t             r_state,   w_state_nxt;
  logic [IN_W-1:0]    r_bin,     w_bin_nxt;
  logic [BCD_W-1:0]   r_scratch, w_scratch_nxt;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [BCD_W-1:0]   r_bcd,     w_bcd_nxt;
  logic               r_done,    w_done_nxt;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_scratch_shift;
  logic               w_unused_carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The top adjusted bit always shifts out as zero for legal parameter sets.
  assign w_unused_carry  = w_adj[BCD_W-1];
  assign w_scratch_shift = {w_adj[BCD_W-2:0], r_bin[IN_W-1]};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_bin_nxt     = r_bin;
    w_scratch_nxt = r_scratch;
    w_cnt_nxt     = r_cnt;
    w_bcd_nxt     = r_bcd;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_bin_nxt     = bin;
          w_scratch_nxt = '0;
          w_cnt_nxt     = CNT_LOAD;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_scratch_nxt = w_scratch_shift;
        w_bin_nxt     = r_bin << 1;
        w_cnt_nxt     = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_bcd_nxt   = w_scratch_shift;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin     <= w_bin_nxt;
      r_scratch <= w_scratch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bcd     <= w_bcd_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_sop_bcd_conv.sv
// Self-checking bench for sop_bcd_conv: directed scenarios, a full 0..511 sweep
// and randomized conversions, all checked against a decimal-split reference.
module tb_sop_bcd_conv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [11:0] exp_hold;

  sop_bcd_conv #(.IN_W(9), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Request a conversion; the accepting edge is the next rising edge.
  task automatic start_req(input logic [8:0] b);
    start = 1'b1;
    bin   = b;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 9'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("done_low_after_accept", 32'(done), 32'd0);
  endtask

  // Follow a conversion to its done pulse, optionally poking start mid-flight.
  task automatic wait_done(input logic [11:0] exp_bcd, input int poke_cycle, input logic [8:0] poke_bin);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      if (cyc == poke_cycle) begin
        start = 1'b1;
        bin   = poke_bin;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done) begin
        got = 1'b1;
        check("latency", 32'(cyc), 32'd9);
        check("busy_in_done_cycle", 32'(busy), 32'd0);
        check("bcd_result", 32'(bcd), 32'(exp_bcd));
      end else begin
        check("busy_during_conv", 32'(busy), 32'd1);
        check("bcd_held", 32'(bcd), 32'(exp_hold));
      end
    end
    check("done_seen", 32'(got), 32'd1);
    exp_hold = exp_bcd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_bcd", 32'(bcd), 32'(exp_hold));
    end
  endtask

  initial begin
    int v;
    int poke;
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    exp_hold = '0;

    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Maximum sum-of-products value
    start_req(9'd450);
    wait_done(12'h450, -1, '0);
    idle(2);

    // Zero, then full-scale chained in the done cycle
    start_req(9'd0);
    wait_done(12'h000, -1, '0);
    start_req(9'd511);
    wait_done(12'h511, -1, '0);
    idle(1);

    // start while busy is ignored
    start_req(9'd255);
    wait_done(12'h255, 4, 9'd7);
    idle(12);

    // Back-to-back: start accepted in the done cycle
    start_req(9'd255);
    wait_done(12'h255, -1, '0);
    start_req(9'd1);
    wait_done(12'h001, -1, '0);
    idle(1);

    // Asynchronous reset mid-conversion
    start_req(9'd123);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #3 rst = 1'b1;
    #1;
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_hold = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(12);
    start_req(9'd99);
    wait_done(12'h099, -1, '0);

    // Exhaustive sweep, back-to-back
    for (int i = 0; i < 512; i++) begin
      start_req(9'(i));
      wait_done(model(i), -1, '0);
    end
    idle(1);

    // Randomized conversions with idle gaps and ignored mid-flight requests
    for (int k = 0; k < 40; k++) begin
      v    = int'($urandom_range(0, 511));
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
      start_req(9'(v));
      wait_done(model(v), poke, 9'($urandom));
      idle(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
